game_score_controller: RTL and testbench

- Parametrised successor to the ad-hoc score/cloud-speed logic in the game top level.
- Owns the game state machine (IDLE/RUN/DEAD), score, BCD score digits for display, persistent high score, difficulty level and scroll speed.
- All logic runs in the CLOCK domain. Event inputs from animation/placer logic are synchronised internally, replacing the old practice of clocking registers on event signals.
- Sits between pipe/collision logic and the drawing controller, LEDs and 7-seg.

---
 rtl/game_pkg.sv | 28 ++
 rtl/bcd_saturating_adder.sv | 41 ++++
 rtl/sync_edge.sv | 39 +++
 rtl/game_score_controller.sv | 155 +++++++++++++++
 tb/tb_game_score_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game score controller: state encoding, BCD digit
// width, synchroniser edge-select constants and a constant BCD conversion helper.
package game_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DEAD = 2'b10;

  localparam int BCD_W = 4;

  // sync_edge output select: rising edge strobe, falling edge strobe, or synchronised level
  localparam logic [1:0] RISE  = 2'd0;
  localparam logic [1:0] FALL  = 2'd1;
  localparam logic [1:0] LEVEL = 2'd2;

  function automatic logic [63:0] to_bcd(input int unsigned value);
    logic [63:0] r;
    int unsigned x;
    r = '0;
    x = value;
    for (int i = 0; i < 16; i++) begin
      r[i*BCD_W +: BCD_W] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_saturating_adder.sv
// Adds the constant POINTS to an N_DIGITS BCD value through a per-digit
// carry chain and clamps the result to BCD(SCORE_MAX).
module bcd_saturating_adder
  import game_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int POINTS    = 5,
  parameter int SCORE_MAX = 9999
) (
  input  logic [BCD_W*N_DIGITS-1:0] a,
  output logic [BCD_W*N_DIGITS-1:0] sum
);

  localparam int W = BCD_W * N_DIGITS;
  localparam logic [W-1:0] PTS_BCD = W'(to_bcd(POINTS));
  localparam logic [W-1:0] MAX_BCD = W'(to_bcd(SCORE_MAX));

  logic [W-1:0]   raw;
  logic           carry;
  logic [BCD_W:0] dsum;

  always_comb begin
    raw   = '0;
    carry = 1'b0;
    dsum  = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      dsum = {1'b0, a[i*BCD_W +: BCD_W]} + {1'b0, PTS_BCD[i*BCD_W +: BCD_W]}
           + {{BCD_W{1'b0}}, carry};
      if (dsum > (BCD_W+1)'(9)) begin
        dsum  = dsum - (BCD_W+1)'(10);
        carry = 1'b1;
      end else begin
        carry = 1'b0;
      end
      raw[i*BCD_W +: BCD_W] = dsum[BCD_W-1:0];
    end
    // Valid BCD vectors order the same way as their binary bit patterns
    sum = (carry || (raw > MAX_BCD)) ? MAX_BCD : raw;
  end

endmodule

// File: rtl/sync_edge.sv
// Two-flop synchroniser plus a history flop; presents either an edge strobe
// or the synchronised level of an asynchronous input.
module sync_edge
  import game_pkg::*;
#(
  parameter logic [1:0] MODE     = RISE,
  parameter logic       IDLE_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic q
);

  logic s1;
  logic s2;
  logic hist;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1   <= IDLE_LVL;
      s2   <= IDLE_LVL;
      hist <= IDLE_LVL;
    end else begin
      s1   <= din;
      s2   <= s1;
      hist <= s2;
    end
  end

  always_comb begin
    case (MODE)
      RISE:    q = s2 & ~hist;
      FALL:    q = ~s2 & hist;
      default: q = s2;
    endcase
  end

endmodule

// File: rtl/game_score_controller.sv
// Game state machine (IDLE/RUN/DEAD) with score, BCD score, high score,
// difficulty level and scroll speed; asynchronous events are synchronised to CLOCK.
module game_score_controller
  import game_pkg::*;
#(
  parameter int SCORE_W     = 14,
  parameter int N_DIGITS    = 4,
  parameter int SCORE_MAX   = 9999,
  parameter int POINTS      = 5,
  parameter int LEVEL_STEP  = 50,
  parameter int N_LEVELS    = 8,
  parameter int BASE_SPEED  = 1,
  parameter int DEAD_FRAMES = 60
) (
  input  logic                        CLOCK,
  input  logic                        reset,
  input  logic                        startBtn,
  input  logic                        pipePassed,
  input  logic                        collision,
  input  logic                        frameTick,
  input  logic                        clearHigh,
  output logic [1:0]                  state,
  output logic [SCORE_W-1:0]          score,
  output logic [BCD_W*N_DIGITS-1:0]   scoreBcd,
  output logic [SCORE_W-1:0]          highScore,
  output logic [$clog2(N_LEVELS)-1:0] level,
  output logic [7:0]                  scrollSpeed,
  output logic                        newRecord
);

  localparam int LVL_W = $clog2(N_LEVELS);
  localparam int DC_W  = $clog2(DEAD_FRAMES + 1);
  localparam int ACC_W = $clog2(LEVEL_STEP + POINTS + 1);

  localparam logic [SCORE_W:0] SUM_MAX    = (SCORE_W+1)'(SCORE_MAX);
  localparam logic [SCORE_W:0] SUM_PTS    = (SCORE_W+1)'(POINTS);
  localparam logic [ACC_W-1:0] ACC_PTS    = ACC_W'(POINTS);
  localparam logic [ACC_W-1:0] ACC_STEP   = ACC_W'(LEVEL_STEP);
  localparam logic [LVL_W-1:0] LVL_MAX    = LVL_W'(N_LEVELS - 1);
  localparam logic [DC_W-1:0]  DEAD_LAST  = DC_W'(DEAD_FRAMES);
  localparam logic [7:0]       SPEED_BASE = 8'(BASE_SPEED);

  logic start_ev;
  logic pipe_ev;
  logic tick_ev;
  logic col_lvl;

  logic [1:0] state_q;
  logic [1:0] state_d;

  logic enter_run;
  logic enter_dead;
  logic score_en;
  logic tick_en;
  logic clear_en;

  logic [DC_W-1:0]           dead_cnt;
  logic [ACC_W-1:0]          level_acc;
  logic [ACC_W-1:0]          acc_sum;
  logic [SCORE_W:0]          score_sum;
  logic [SCORE_W-1:0]        score_next;
  logic [BCD_W*N_DIGITS-1:0] bcd_next;

  sync_edge #(.MODE(FALL),  .IDLE_LVL(1'b1)) u_sync_start (
    .clk(CLOCK), .reset(reset), .din(startBtn),   .q(start_ev));
  sync_edge #(.MODE(RISE),  .IDLE_LVL(1'b0)) u_sync_pipe (
    .clk(CLOCK), .reset(reset), .din(pipePassed), .q(pipe_ev));
  sync_edge #(.MODE(RISE),  .IDLE_LVL(1'b0)) u_sync_tick (
    .clk(CLOCK), .reset(reset), .din(frameTick),  .q(tick_ev));
  sync_edge #(.MODE(LEVEL), .IDLE_LVL(1'b0)) u_sync_col (
    .clk(CLOCK), .reset(reset), .din(collision),  .q(col_lvl));

  bcd_saturating_adder #(
    .N_DIGITS (N_DIGITS),
    .POINTS   (POINTS),
    .SCORE_MAX(SCORE_MAX)
  ) u_bcd_add (
    .a  (scoreBcd),
    .sum(bcd_next)
  );

  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_ev) state_d = ST_RUN;
      ST_RUN:  if (col_lvl) state_d = ST_DEAD;
      ST_DEAD: if (start_ev && (dead_cnt == DEAD_LAST)) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Collision beats a simultaneous pipe event; DEAD only counts ticks up to the lockout
  always_comb begin
    state      = state_q;
    enter_run  = (state_d == ST_RUN) && (state_q != ST_RUN);
    enter_dead = (state_d == ST_DEAD) && (state_q == ST_RUN);
    score_en   = (state_q == ST_RUN) && !col_lvl && pipe_ev;
    tick_en    = (state_q == ST_DEAD) && tick_ev && (dead_cnt != DEAD_LAST);
    clear_en   = (state_q == ST_IDLE) && clearHigh;
  end

  always_comb begin
    score_sum  = {1'b0, score} + SUM_PTS;
    score_next = (score_sum > SUM_MAX) ? SUM_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    acc_sum    = level_acc + ACC_PTS;
  end

  always_ff @(posedge CLOCK) begin
    if (!reset) begin
      score       <= '0;
      scoreBcd    <= '0;
      highScore   <= '0;
      level       <= '0;
      level_acc   <= '0;
      dead_cnt    <= '0;
      newRecord   <= 1'b0;
      scrollSpeed <= SPEED_BASE;
    end else begin
      scrollSpeed <= SPEED_BASE + 8'(level);
      if (enter_run) begin
        score     <= '0;
        scoreBcd  <= '0;
        level     <= '0;
        level_acc <= '0;
        newRecord <= 1'b0;
      end else if (enter_dead) begin
        dead_cnt <= '0;
        if (score > highScore) begin
          highScore <= score;
          newRecord <= 1'b1;
        end
      end else if (score_en) begin
        score    <= score_next;
        scoreBcd <= bcd_next;
        if (acc_sum >= ACC_STEP) begin
          level_acc <= acc_sum - ACC_STEP;
          if (level != LVL_MAX) level <= level + LVL_W'(1);
        end else begin
          level_acc <= acc_sum;
        end
      end
      if (tick_en) dead_cnt <= dead_cnt + DC_W'(1);
      if (clear_en) highScore <= '0;
    end
  end

endmodule

// File: tb/tb_game_score_controller.sv
// Randomised bench for game_score_controller: a behavioural model predicts every
// output change with its cycle, a monitor compares each change the DUT presents.
module tb_game_score_controller;

  localparam int SNAP_W = 58;
  localparam int CYC_W  = 20;
  localparam int W      = SNAP_W + CYC_W;

  localparam int POINTS      = 5;
  localparam int SCORE_MAX   = 9999;
  localparam int LEVEL_STEP  = 50;
  localparam int N_LEVELS    = 8;
  localparam int BASE_SPEED  = 1;
  localparam int DEAD_FRAMES = 60;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset       = 1'b0;
  logic start_btn   = 1'b1;
  logic pipe_passed = 1'b0;
  logic collision   = 1'b0;
  logic frame_tick  = 1'b0;
  logic clear_high  = 1'b0;

  logic [1:0]  state;
  logic [13:0] score;
  logic [15:0] score_bcd;
  logic [13:0] high_score;
  logic [2:0]  level;
  logic [7:0]  scroll_speed;
  logic        new_record;

  game_score_controller #(
    .SCORE_W(14), .N_DIGITS(4), .SCORE_MAX(SCORE_MAX), .POINTS(POINTS),
    .LEVEL_STEP(LEVEL_STEP), .N_LEVELS(N_LEVELS), .BASE_SPEED(BASE_SPEED),
    .DEAD_FRAMES(DEAD_FRAMES)
  ) dut (
    .CLOCK(clk), .reset(reset), .startBtn(start_btn), .pipePassed(pipe_passed),
    .collision(collision), .frameTick(frame_tick), .clearHigh(clear_high),
    .state(state), .score(score), .scoreBcd(score_bcd), .highScore(high_score),
    .level(level), .scrollSpeed(scroll_speed), .newRecord(new_record)
  );

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic logic [15:0] dec_to_bcd(input int v);
    logic [15:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  function automatic string fmt(input logic [SNAP_W-1:0] s);
    return $sformatf("st=%0d score=%0d bcd=%h high=%0d level=%0d speed=%0d rec=%0d",
                     s[57:56], s[55:42], s[41:26], s[25:12], s[11:9], s[8:1], s[0]);
  endfunction

  // reference model: game rules on integers, events seen through 2-flop sync + history
  int m_cyc = 0;
  int m_state = 0;
  int m_score = 0, m_high = 0, m_level = 0, m_acc = 0, m_dead = 0, m_speed = BASE_SPEED;
  bit m_new = 1'b0;
  bit p_d[3], c_d[3], t_d[3], s_d[3];
  logic [SNAP_W-1:0] last_snap = 'x;

  always @(posedge clk) begin
    bit ev_pipe, ev_tick, ev_start, lvl_col;
    int old_dead;
    logic [SNAP_W-1:0] snap;
    m_cyc++;
    if (!reset) begin
      m_state = 0; m_score = 0; m_high = 0; m_level = 0; m_acc = 0;
      m_dead = 0; m_speed = BASE_SPEED; m_new = 1'b0;
      for (int i = 0; i < 3; i++) begin
        p_d[i] = 1'b0; c_d[i] = 1'b0; t_d[i] = 1'b0; s_d[i] = 1'b1;
      end
    end else begin
      ev_pipe  = p_d[1] && !p_d[2];
      ev_tick  = t_d[1] && !t_d[2];
      ev_start = !s_d[1] && s_d[2];
      lvl_col  = c_d[1];
      m_speed  = BASE_SPEED + m_level;
      case (m_state)
        0: begin
          if (clear_high) m_high = 0;
          if (ev_start) begin
            m_state = 1; m_score = 0; m_level = 0; m_acc = 0; m_new = 1'b0;
          end
        end
        1: begin
          if (lvl_col) begin
            m_state = 2; m_dead = 0;
            if (m_score > m_high) begin m_high = m_score; m_new = 1'b1; end
          end else if (ev_pipe) begin
            m_score = (m_score + POINTS > SCORE_MAX) ? SCORE_MAX : m_score + POINTS;
            m_acc = m_acc + POINTS;
            if (m_acc >= LEVEL_STEP) begin
              m_acc = m_acc - LEVEL_STEP;
              if (m_level < N_LEVELS - 1) m_level++;
            end
          end
        end
        default: begin
          old_dead = m_dead;
          if (ev_tick && m_dead < DEAD_FRAMES) m_dead++;
          if (ev_start && old_dead == DEAD_FRAMES) begin
            m_state = 1; m_score = 0; m_level = 0; m_acc = 0; m_new = 1'b0;
          end
        end
      endcase
      p_d[2] = p_d[1]; p_d[1] = p_d[0]; p_d[0] = pipe_passed;
      c_d[2] = c_d[1]; c_d[1] = c_d[0]; c_d[0] = collision;
      t_d[2] = t_d[1]; t_d[1] = t_d[0]; t_d[0] = frame_tick;
      s_d[2] = s_d[1]; s_d[1] = s_d[0]; s_d[0] = start_btn;
    end
    snap = {2'(m_state), 14'(m_score), dec_to_bcd(m_score), 14'(m_high),
            3'(m_level), 8'(m_speed), m_new};
    if (snap !== last_snap) begin
      exp_q.push_back({CYC_W'(m_cyc), snap});
      last_snap = snap;
    end
  end

  // monitor: every change on the outputs must match the next predicted change and cycle
  int mon_cyc = 0;
  logic [SNAP_W-1:0] prev_obs = 'x;

  always @(negedge clk) begin
    logic [SNAP_W-1:0] obs;
    logic [W-1:0] exp_e;
    mon_cyc++;
    obs = {state, score, score_bcd, high_score, level, scroll_speed, new_record};
    if (obs !== prev_obs) begin
      prev_obs = obs;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d actual %s required no change", mon_cyc, fmt(obs));
      end else begin
        exp_e = exp_q.pop_front();
        if (exp_e[SNAP_W-1:0] !== obs || exp_e[W-1:SNAP_W] != CYC_W'(mon_cyc)) begin
          n_bad++;
          $display("FAIL output_change actual cyc=%0d %s required cyc=%0d %s",
                   mon_cyc, fmt(obs), exp_e[W-1:SNAP_W], fmt(exp_e[SNAP_W-1:0]));
        end
      end
    end
  end

  // driver tasks: all start and end just after a falling edge
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pipe(input bit with_col);
    pipe_passed = 1'b1;
    if (with_col) collision = 1'b1;
    wait_cycles($urandom_range(1, 2));
    pipe_passed = 1'b0;
    collision   = 1'b0;
    wait_cycles($urandom_range(1, 2));
  endtask

  task automatic press_start();
    start_btn = 1'b0;
    wait_cycles($urandom_range(1, 3));
    start_btn = 1'b1;
    wait_cycles($urandom_range(1, 3));
  endtask

  task automatic frame_ticks(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      wait_cycles(1);
      frame_tick = 1'b0;
      wait_cycles($urandom_range(1, 2));
    end
  endtask

  task automatic random_phase(input int n);
    repeat (n) begin
      pipe_passed = ($urandom_range(0, 9) < 4);
      collision   = ($urandom_range(0, 99) < 2);
      frame_tick  = ($urandom_range(0, 1) == 1);
      start_btn   = !($urandom_range(0, 99) < 5);
      clear_high  = ($urandom_range(0, 99) < 5);
      wait_cycles(1);
    end
    pipe_passed = 1'b0; collision = 1'b0; frame_tick = 1'b0;
    start_btn = 1'b1; clear_high = 1'b0;
    wait_cycles(3);
  endtask

  initial begin
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);
    press_start();
    wait_cycles(4);
    repeat (9) pulse_pipe(1'b0);
    wait_cycles(3);
    pulse_pipe(1'b1);
    wait_cycles(4);
    frame_ticks(30);
    press_start();
    frame_ticks(35);
    press_start();
    wait_cycles(4);
    clear_high = 1'b1;
    wait_cycles(3);
    clear_high = 1'b0;
    repeat (10) pulse_pipe(1'b0);
    pulse_pipe(1'b1);
    frame_ticks(62);
    press_start();
    wait_cycles(4);
    repeat (2000) pulse_pipe(1'b0);
    repeat (5) pulse_pipe(1'b0);
    random_phase(1500);
    frame_ticks(62);
    press_start();
    wait_cycles(4);
    repeat (4) pulse_pipe(1'b0);
    reset = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    wait_cycles(3);
    clear_high = 1'b1;
    wait_cycles(2);
    clear_high = 1'b0;
    press_start();
    repeat (3) pulse_pipe(1'b0);
    wait_cycles(10);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_changes actual=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
